ps2_scancode_parser: RTL and testbench

- Front end of the keyboard path: receives raw PS/2 serial frames from the keyboard pins.
- Assembles the bytes and folds Set-2 prefixes (E0 extended, F0 break) into one 9-bit keyCode.
- Emits single-cycle make/brakee strobes for the downstream key decoder, which compares keyCode against its key table on the cycle a strobe is high.

---
 rtl/ps2_scancode_parser.sv | 215 +++++++++++++++++++++
 tb/tb_ps2_scancode_parser.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_parser.sv
// PS/2 keyboard front end: pin sync, clock glitch filter, frame receiver and Set-2 prefix folding.
// Optional TYPEMATIC_FILTER_EN suppresses repeated makes of the same key until its break.
module ps2_scancode_parser #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [8:0] keyCode,
    output logic       make,
    output logic       brakee,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // state | meaning
    // IDLE  | no prefix pending
    // EXT   | E0 seen, waiting for code or F0
    // BRK   | F0 seen (ext holds E0 flag), next byte is a break code
    // PAUSE | E1 seen, swallowing the rest of the pause sequence
    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_PAUSE} state_t;

    logic [1:0]    clk_sync, data_sync;
    logic [FW-1:0] flt_cnt;
    logic          clk_flt, fall, data_bit;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par, rx_valid, rx_err;
    logic [TW-1:0] tmo;
    state_t        state, state_nx;
    logic          ext, ext_nx;
    logic [2:0]    skip, skip_nx;
    logic          make_nx, brk_nx, make_raw;
    logic [8:0]    code_nx;
    logic          suppress;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            flt_cnt  <= '0;
            clk_flt  <= 1'b1;
            fall     <= 1'b0;
            data_bit <= 1'b1;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == clk_flt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                flt_cnt  <= '0;
                clk_flt  <= clk_sync[1];
                fall     <= ~clk_sync[1];
                data_bit <= data_sync[1];
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            tmo      <= TW'(TIMEOUT_CYCLES - 1);
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (fall) begin
                tmo <= TW'(TIMEOUT_CYCLES - 1);
                case (bit_cnt)
                    4'd0: begin
                        if (!data_bit) bit_cnt <= 4'd1;
                        else           rx_err  <= 1'b1;
                    end
                    4'd9: begin
                        par     <= data_bit;
                        bit_cnt <= 4'd10;
                    end
                    4'd10: begin
                        bit_cnt <= 4'd0;
                        if (data_bit && (^{shreg, par})) rx_valid <= 1'b1;
                        else                             rx_err   <= 1'b1;
                    end
                    default: begin
                        shreg   <= {data_bit, shreg[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                endcase
            end else if (bit_cnt != 4'd0) begin
                if (tmo == '0) begin
                    rx_err  <= 1'b1;
                    bit_cnt <= 4'd0;
                end else begin
                    tmo <= tmo - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= S_IDLE;
            ext       <= 1'b0;
            skip      <= '0;
            make      <= 1'b0;
            brakee    <= 1'b0;
            frame_err <= 1'b0;
            keyCode   <= 9'h000;
        end else begin
            state     <= state_nx;
            ext       <= ext_nx;
            skip      <= skip_nx;
            make      <= make_nx;
            brakee    <= brk_nx;
            frame_err <= rx_err;
            if (make_nx || brk_nx) keyCode <= code_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ext_nx   = ext;
        skip_nx  = skip;
        if (rx_err) begin
            state_nx = S_IDLE;
        end else if (rx_valid) begin
            case (state)
                S_IDLE: begin
                    if (shreg == 8'hE0) begin
                        state_nx = S_EXT;
                    end else if (shreg == 8'hF0) begin
                        state_nx = S_BRK;
                        ext_nx   = 1'b0;
                    end else if (shreg == 8'hE1) begin
                        state_nx = S_PAUSE;
                        skip_nx  = 3'd7;
                    end
                end
                S_EXT: begin
                    if (shreg == 8'hF0) begin
                        state_nx = S_BRK;
                        ext_nx   = 1'b1;
                    end else if (shreg != 8'hE0) begin
                        state_nx = S_IDLE;
                    end
                end
                S_BRK: state_nx = S_IDLE;
                S_PAUSE: begin
                    skip_nx = skip - 3'd1;
                    if (skip == 3'd1) state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        make_raw = 1'b0;
        brk_nx   = 1'b0;
        code_nx  = {1'b0, shreg};
        if (rx_valid && !rx_err) begin
            case (state)
                S_IDLE: make_raw = !(shreg inside {8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hAA,
                                                    8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF});
                S_EXT: begin
                    make_raw = !(shreg inside {8'hE0, 8'hF0});
                    code_nx  = {1'b1, shreg};
                end
                S_BRK: begin
                    brk_nx  = 1'b1;
                    code_nx = {ext, shreg};
                end
                default: ;
            endcase
        end
        make_nx = make_raw && !suppress;
    end

`ifdef TYPEMATIC_FILTER_EN
    logic [8:0] last_made;
    logic       last_valid;

    assign suppress = last_valid && (last_made == code_nx);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            last_made  <= 9'h000;
            last_valid <= 1'b0;
        end else if (make_nx) begin
            last_made  <= code_nx;
            last_valid <= 1'b1;
        end else if (brk_nx && (code_nx == last_made)) begin
            last_valid <= 1'b0;
        end
    end
`else
    assign suppress = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_scancode_parser.sv
// Scoreboard bench for ps2_scancode_parser: a byte-level prefix model predicts strobes,
// a negedge monitor pops and compares whenever the DUT strobes.
module tb_ps2_scancode_parser;
    localparam int HALF = 15;
    localparam int TMO  = 1000;
    localparam logic [1:0] K_MAKE = 2'd0, K_BRK = 2'd1, K_ERR = 2'd2;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [8:0] keyCode;
    logic       make, brakee, frame_err;

    ps2_scancode_parser #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .resetN(resetN), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keyCode(keyCode), .make(make), .brakee(brakee), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] kind;
        logic [8:0] code;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    // Model: pending prefix flags and pause-skip count, plus typematic memory.
    bit       m_ext, m_brk;
    int       m_skip;
    bit [8:0] m_last;
    bit       m_last_v;

    function automatic void push(input logic [1:0] k, input logic [8:0] c);
        ev_t e;
        e.kind = k;
        e.code = c;
        exp_q.push_back(e);
    endfunction

    function automatic void model_clear_prefix();
        m_ext  = 0;
        m_brk  = 0;
        m_skip = 0;
    endfunction

    function automatic void emit_make(input logic [8:0] c);
`ifdef TYPEMATIC_FILTER_EN
        if (m_last_v && m_last == c) return;
        m_last   = c;
        m_last_v = 1;
`endif
        push(K_MAKE, c);
    endfunction

    function automatic void emit_brk(input logic [8:0] c);
`ifdef TYPEMATIC_FILTER_EN
        if (m_last == c) m_last_v = 0;
`endif
        push(K_BRK, c);
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (m_skip > 0) begin
            m_skip--;
        end else if (m_brk) begin
            emit_brk({m_ext, b});
            model_clear_prefix();
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1;
            else if (b != 8'hE0) begin
                emit_make({1'b1, b});
                m_ext = 0;
            end
        end else if (b == 8'hE1) m_skip = 7;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF}))
            emit_make({1'b0, b});
    endfunction

    task automatic drive_bit(input logic v);
        ps2_data = v;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic [10:0] f;
        if (bad_par) begin
            push(K_ERR, 9'h000);
            model_clear_prefix();
        end else begin
            model_byte(b);
        end
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) drive_bit(f[i]);
        repeat (2 * HALF) @(posedge clk);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        logic [10:0] f;
        f = {1'b1, ~^b, b, 1'b0};
        for (int i = 0; i < nbits; i++) drive_bit(f[i]);
    endtask

    logic       prev_strobe = 1'b0;
    ev_t        mon_e;
    logic [1:0] act_kind;

    always @(negedge clk) begin
        if (!resetN) begin
            n_cmp++;
            if (make || brakee || frame_err || keyCode != 9'h000) begin
                n_err++;
                $display("FAIL reset_outputs: got make=%b brakee=%b frame_err=%b keyCode=%h, want all 0",
                         make, brakee, frame_err, keyCode);
            end
            prev_strobe <= 1'b0;
        end else begin
            if (prev_strobe) begin
                n_cmp++;
                if (make || brakee || frame_err) begin
                    n_err++;
                    $display("FAIL pulse_width: strobe still high (make=%b brakee=%b frame_err=%b), want 1-cycle pulse",
                             make, brakee, frame_err);
                end
            end
            if (make || brakee || frame_err) begin
                n_cmp++;
                act_kind = make ? K_MAKE : (brakee ? K_BRK : K_ERR);
                if ((make && brakee) || ((make || brakee) && frame_err)) begin
                    n_err++;
                    $display("FAIL exclusive: make=%b brakee=%b frame_err=%b together", make, brakee, frame_err);
                end else if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_strobe: got kind=%0d keyCode=%h, want no strobe", act_kind, keyCode);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (act_kind != mon_e.kind || (act_kind != K_ERR && keyCode != mon_e.code)) begin
                        n_err++;
                        $display("FAIL strobe: got kind=%0d keyCode=%h, want kind=%0d keyCode=%h",
                                 act_kind, keyCode, mon_e.kind, mon_e.code);
                    end
                end
            end
            prev_strobe <= make | brakee | frame_err;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pool[10];
        logic [7:0] b;
        int r;
        pool = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF, 8'hE0, 8'hF0, 8'h1C};
        model_clear_prefix();
        m_last   = '0;
        m_last_v = 0;

        repeat (5) @(posedge clk);
        resetN = 1'b1;
        repeat (10) @(posedge clk);

        send_frame(8'h1C, 0);
        send_frame(8'hE0, 0); send_frame(8'h75, 0);
        send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0);
        send_frame(8'h29, 1);
        send_frame(8'hF0, 0); send_frame(8'h29, 0);

        // Partial frame then silence longer than the timeout.
        push(K_ERR, 9'h000);
        model_clear_prefix();
        send_partial(8'h33, 5);
        repeat (TMO + 200) @(posedge clk);
        send_frame(8'h5A, 0);

        // Reset in the middle of the frame following an E0 prefix.
        send_frame(8'hE0, 0);
        send_partial(8'h44, 5);
        @(posedge clk);
        resetN = 1'b0;
        repeat (3) @(posedge clk);
        exp_q.delete();
        model_clear_prefix();
        m_last_v = 0;
        m_last   = '0;
        resetN = 1'b1;
        repeat (10) @(posedge clk);
        send_frame(8'h1D, 0);

        foreach (pool[i]) if (i < 0) pool[i] = 0;
        send_frame(8'hE1, 0); send_frame(8'h14, 0); send_frame(8'h77, 0); send_frame(8'hE1, 0);
        send_frame(8'hF0, 0); send_frame(8'h14, 0); send_frame(8'hF0, 0); send_frame(8'h77, 0);
        send_frame(8'h23, 0);

        send_frame(8'h1C, 0); send_frame(8'h1C, 0); send_frame(8'h1C, 0);
        send_frame(8'hF0, 0); send_frame(8'h1C, 0);
        send_frame(8'h1C, 0);

        for (int n = 0; n < 55; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       b = pool[$urandom_range(0, 9)];
            else if (r == 4) b = 8'hE1;
            else             b = 8'($urandom_range(0, 255));
            send_frame(b, $urandom_range(0, 9) == 0);
        end

        repeat (50) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expected: got %0d unmatched events, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
